// File: rtl/lc3_pkg.sv
// ---------------------------------------------------------------------------
// lc3_pkg
// Shared types and constants for the LC-3 memory/IO controller slice.
//   word_t        16-bit LC-3 machine word
//   *_ADDR        memory-mapped device register addresses
//   IO_PAGE_BASE  first address of the I/O page (xFE00-xFFFF)
//   mem_state_t   controller FSM states
// ---------------------------------------------------------------------------
package lc3_pkg;

    typedef logic [15:0] word_t;

    localparam word_t IO_PAGE_BASE = 16'hFE00;
    localparam word_t KBSR_ADDR    = 16'hFE00;
    localparam word_t KBDR_ADDR    = 16'hFE02;
    localparam word_t DSR_ADDR     = 16'hFE04;
    localparam word_t DDR_ADDR     = 16'hFE06;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // The whole top page of the address space belongs to devices, never RAM.
    function automatic logic is_io_addr(input word_t addr);
        return (addr >= IO_PAGE_BASE);
    endfunction

endpackage

// File: rtl/lc3_ram.sv
// ---------------------------------------------------------------------------
// lc3_ram
// Single-port word RAM, synchronous write, registered read. Only touched on
// the controller's access edge. Contents are deliberately not reset.
//   i_clk    clock
//   i_en     access enable (one cycle)
//   i_we     1 = write i_wdata, 0 = read into the output register
//   i_addr   word index (RAM_ADDR_W bits)
//   i_wdata  write data
//   o_rdata  registered read data, held until the next read
// ---------------------------------------------------------------------------
module lc3_ram
    import lc3_pkg::*;
#(
    parameter int RAM_ADDR_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [RAM_ADDR_W-1:0] i_addr,
    input  word_t                 i_wdata,
    output word_t                 o_rdata
);

    word_t r_mem [0:(2**RAM_ADDR_W)-1];
    word_t r_rdata;

    // Write updates the array; a read loads the output register, which a write leaves untouched.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/lc3_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lc3_mem_ctrl
// Memory/IO controller behind the LC-3 MAR/MDR. Accepts one access at a time
// with a fixed LATENCY, decodes the device page (KBSR/KBDR/DSR/DDR) and backs
// every other address with lc3_ram.
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_mem_en, i_mem_we  access request / direction (sampled when idle)
//   i_mar, i_mdr_in     address and write data (latched at accept)
//   o_mdr_out           read data, held until the next read completes
//   o_mem_ready         one-cycle completion pulse
//   i_kbd_valid/data    keyboard stream in;  o_kbd_ready = ~KBSR[15]
//   o_disp_valid/data   display stream out;  i_disp_ready
// ---------------------------------------------------------------------------
module lc3_mem_ctrl
    import lc3_pkg::*;
#(
    parameter int LATENCY    = 2,
    parameter int RAM_ADDR_W = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_en,
    input  logic        i_mem_we,
    input  logic [15:0] i_mar,
    input  logic [15:0] i_mdr_in,
    output logic [15:0] o_mdr_out,
    output logic        o_mem_ready,
    input  logic        i_kbd_valid,
    input  logic [7:0]  i_kbd_data,
    output logic        o_kbd_ready,
    output logic        o_disp_valid,
    output logic [7:0]  o_disp_data,
    input  logic        i_disp_ready
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    mem_state_t r_state;
    logic [3:0] r_cnt;
    word_t      r_mar;
    word_t      r_mdr;
    logic       r_we;
    logic       r_mem_ready;
    word_t      r_io_rdata;
    logic       r_rd_ram;      // last completed read came from RAM
    logic       r_kbsr_full;   // KBSR[15]
    logic [7:0] r_kbdr;
    logic       r_dsr_ready;   // DSR[15]
    logic       r_disp_valid;
    logic [7:0] r_disp_data;

    logic       w_access;
    logic       w_is_io;
    logic       w_kbd_xfer;
    word_t      w_io_rdata;
    word_t      w_ram_rdata;

    // A reset landing on the access edge must suppress the RAM write too.
    assign w_access   = (r_state == BUSY) && (r_cnt == 4'd0) && !i_rst;
    assign w_is_io    = is_io_addr(r_mar);
    assign w_kbd_xfer = i_kbd_valid && !r_kbsr_full;

    // Device register read mux on the latched address.
    always_comb begin
        w_io_rdata = 16'h0000;
        case (r_mar)
            KBSR_ADDR: w_io_rdata = {r_kbsr_full, 15'h0000};
            KBDR_ADDR: w_io_rdata = {8'h00, r_kbdr};
            DSR_ADDR:  w_io_rdata = {r_dsr_ready, 15'h0000};
            default:   w_io_rdata = 16'h0000;
        endcase
    end

    lc3_ram #(
        .RAM_ADDR_W (RAM_ADDR_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_en    (w_access && !w_is_io),
        .i_we    (r_we),
        .i_addr  (r_mar[RAM_ADDR_W-1:0]),
        .i_wdata (r_mdr),
        .o_rdata (w_ram_rdata)
    );

    // Access FSM, latency counter and device registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_mar        <= 16'h0000;
            r_mdr        <= 16'h0000;
            r_we         <= 1'b0;
            r_mem_ready  <= 1'b0;
            r_io_rdata   <= 16'h0000;
            r_rd_ram     <= 1'b0;
            r_kbsr_full  <= 1'b0;
            r_kbdr       <= 8'h00;
            r_dsr_ready  <= 1'b1;
            r_disp_valid <= 1'b0;
            r_disp_data  <= 8'h00;
        end else begin
            r_mem_ready <= 1'b0;

            if (w_kbd_xfer) begin
                r_kbdr      <= i_kbd_data;
                r_kbsr_full <= 1'b1;
            end

            if (r_disp_valid && i_disp_ready) begin
                r_disp_valid <= 1'b0;
                r_dsr_ready  <= 1'b1;
            end

            case (r_state)
                // DONE is the mem_ready cycle; it accepts a new request just like IDLE.
                IDLE, DONE: begin
                    if (i_mem_en) begin
                        r_mar   <= i_mar;
                        r_mdr   <= i_mdr_in;
                        r_we    <= i_mem_we;
                        r_cnt   <= CNT_LOAD;
                        r_state <= BUSY;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_mem_ready <= 1'b1;
                        r_state     <= DONE;
                        if (!r_we) begin
                            r_rd_ram   <= !w_is_io;
                            r_io_rdata <= w_io_rdata;
                            // Placed after the keyboard update so the clear wins a same-edge transfer.
                            if (r_mar == KBDR_ADDR) begin
                                r_kbsr_full <= 1'b0;
                            end
                        end else if ((r_mar == DDR_ADDR) && r_dsr_ready) begin
                            r_disp_data  <= r_mdr[7:0];
                            r_disp_valid <= 1'b1;
                            r_dsr_ready  <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Both sources are registers; the select only moves when a read completes.
    assign o_mdr_out    = r_rd_ram ? w_ram_rdata : r_io_rdata;
    assign o_mem_ready  = r_mem_ready;
    assign o_kbd_ready  = !r_kbsr_full;
    assign o_disp_valid = r_disp_valid;
    assign o_disp_data  = r_disp_data;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lc3_mem_ctrl
// Self-checking bench for lc3_mem_ctrl against a behavioural model of the
// memory map (array RAM with aliasing, KBSR/KBDR/DSR/DDR as plain flags).
// ---------------------------------------------------------------------------
module tb_lc3_mem_ctrl;

    localparam int LAT = 3;
    localparam int AW  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_en = 1'b0;
    logic        mem_we = 1'b0;
    logic [15:0] mar = 16'h0000;
    logic [15:0] mdr_in = 16'h0000;
    logic [15:0] mdr_out;
    logic        mem_ready;
    logic        kbd_valid = 1'b0;
    logic [7:0]  kbd_data = 8'h00;
    logic        kbd_ready;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ready = 1'b0;

    always #5 clk = ~clk;

    lc3_mem_ctrl #(
        .LATENCY    (LAT),
        .RAM_ADDR_W (AW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_mem_en     (mem_en),
        .i_mem_we     (mem_we),
        .i_mar        (mar),
        .i_mdr_in     (mdr_in),
        .o_mdr_out    (mdr_out),
        .o_mem_ready  (mem_ready),
        .i_kbd_valid  (kbd_valid),
        .i_kbd_data   (kbd_data),
        .o_kbd_ready  (kbd_ready),
        .o_disp_valid (disp_valid),
        .o_disp_data  (disp_data),
        .i_disp_ready (disp_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_ram [256];
    bit          m_known [256];
    bit          m_full;
    logic [7:0]  m_kbdr;
    bit          m_dsr;
    bit          m_dv;
    logic [7:0]  m_dd;
    logic [15:0] m_last;
    bit          m_last_ok;

    task automatic model_reset();
        m_full = 1'b0; m_kbdr = 8'h00; m_dsr = 1'b1; m_dv = 1'b0; m_dd = 8'h00;
        m_last = 16'h0000; m_last_ok = 1'b1;
    endtask

    task automatic model_access(input bit we, input logic [15:0] a, input logic [15:0] d,
                                output bit chk, output logic [15:0] rd);
        int idx;
        chk = 1'b0;
        rd  = 16'h0000;
        if (a >= 16'hFE00) begin
            if (!we) begin
                chk = 1'b1;
                if (a == 16'hFE00)      rd = m_full ? 16'h8000 : 16'h0000;
                else if (a == 16'hFE02) rd = {8'h00, m_kbdr};
                else if (a == 16'hFE04) rd = m_dsr ? 16'h8000 : 16'h0000;
                else                    rd = 16'h0000;
                if (a == 16'hFE02) m_full = 1'b0;
            end else if (a == 16'hFE06 && m_dsr) begin
                m_dd = d[7:0]; m_dv = 1'b1; m_dsr = 1'b0;
            end
        end else begin
            idx = int'(a) % 256;
            if (we) begin
                m_ram[idx] = d; m_known[idx] = 1'b1;
            end else begin
                chk = m_known[idx]; rd = m_ram[idx];
            end
        end
        if (!we) begin
            m_last = rd; m_last_ok = chk;
        end
    endtask

    task automatic check_io(input string tag);
        check_eq({tag, " kbd_ready"},  {15'h0000, kbd_ready},  {15'h0000, !m_full});
        check_eq({tag, " disp_valid"}, {15'h0000, disp_valid}, {15'h0000, m_dv});
        check_eq({tag, " disp_data"},  {8'h00, disp_data},     {8'h00, m_dd});
    endtask

    // One complete access; checks latency, read data / held data, pulse width.
    task automatic access(input bit we, input logic [15:0] a, input logic [15:0] d, input string tag);
        bit          c;
        logic [15:0] e;
        int          k;
        model_access(we, a, d, c, e);
        @(negedge clk);
        mem_en = 1'b1; mem_we = we; mar = a; mdr_in = d;
        @(posedge clk);
        #1;
        mem_en = 1'b0; mem_we = 1'($urandom); mar = 16'($urandom); mdr_in = 16'($urandom);
        k = 0;
        while (k < 20) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (mem_ready) break;
        end
        check_eq({tag, " latency"}, 16'(k), 16'(LAT));
        if (!we && c)           check_eq({tag, " rdata"}, mdr_out, e);
        if (we && m_last_ok)    check_eq({tag, " held"},  mdr_out, m_last);
        @(negedge clk);
        check_eq({tag, " pulse"}, {15'h0000, mem_ready}, 16'h0000);
        check_io(tag);
    endtask

    task automatic kbd_offer(input logic [7:0] ch);
        @(negedge clk);
        kbd_valid = 1'b1; kbd_data = ch;
        @(posedge clk);
        #1 kbd_valid = 1'b0;
        if (!m_full) begin m_full = 1'b1; m_kbdr = ch; end
        @(negedge clk);
        check_io("kbd");
    endtask

    task automatic disp_pulse();
        @(negedge clk);
        disp_ready = 1'b1;
        @(posedge clk);
        #1 disp_ready = 1'b0;
        if (m_dv) begin m_dv = 1'b0; m_dsr = 1'b1; end
        @(negedge clk);
        check_io("disp");
    endtask

    // Reset asserted on the d-th edge after accepting a write.
    task automatic reset_during_write(input int d);
        logic [15:0] old_v;
        int          pulses;
        old_v = 16'($urandom);
        access(1'b1, 16'h4000, old_v, "rst pre");
        @(negedge clk);
        mem_en = 1'b1; mem_we = 1'b1; mar = 16'h4000; mdr_in = 16'h1234;
        @(posedge clk);
        for (int i = 1; i < d; i++) @(posedge clk);
        #1;
        mem_en = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 2 * LAT + 2; i++) begin
            @(negedge clk);
            if (mem_ready) pulses++;
        end
        model_reset();
        check_eq("rst no ready", 16'(pulses), 16'h0000);
        check_eq("rst mdr_out", mdr_out, 16'h0000);
        check_io("rst");
        access(1'b0, 16'h4000, 16'h0000, "rst readback");
    endtask

    initial begin
        logic [15:0] a;
        int          op;
        int          cyc;
        int          got;
        int          t [3];
        bit          c;
        logic [15:0] e;

        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("reset mdr_out", mdr_out, 16'h0000);
        check_eq("reset mem_ready", {15'h0000, mem_ready}, 16'h0000);
        check_io("reset");

        // RAM write/read
        access(1'b1, 16'h3000, 16'hBEEF, "t1 wr");
        access(1'b0, 16'h3000, 16'h0000, "t1 rd");

        // keyboard
        kbd_offer(8'h41);
        access(1'b0, 16'hFE00, 16'h0000, "t2 kbsr");
        access(1'b0, 16'hFE02, 16'h0000, "t2 kbdr");
        access(1'b0, 16'hFE00, 16'h0000, "t2 kbsr2");

        // display
        access(1'b1, 16'hFE06, 16'h0048, "t3 ddr");
        access(1'b0, 16'hFE04, 16'h0000, "t3 dsr busy");
        access(1'b1, 16'hFE06, 16'h0049, "t3 ddr drop");
        disp_pulse();
        access(1'b0, 16'hFE04, 16'h0000, "t3 dsr idle");

        // back-to-back reads with mem_en held high
        for (int i = 0; i < 3; i++) access(1'b1, 16'(i), 16'($urandom), "t4 pre");
        @(negedge clk);
        mem_en = 1'b1; mem_we = 1'b0; mar = 16'h0000;
        cyc = 0; got = 0;
        while (got < 3 && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (mem_ready) begin
                t[got] = cyc;
                model_access(1'b0, 16'(got), 16'h0000, c, e);
                check_eq("t4 rdata", mdr_out, e);
                got++;
                if (got < 3) mar = 16'(got);
                else         mem_en = 1'b0;
            end
        end
        mem_en = 1'b0;
        check_eq("t4 count", 16'(got), 16'd3);
        check_eq("t4 first", 16'(t[0]), 16'(LAT + 1));
        check_eq("t4 gap1", 16'(t[1] - t[0]), 16'(LAT + 1));
        check_eq("t4 gap2", 16'(t[2] - t[1]), 16'(LAT + 1));

        // reset mid-access, including on the access edge itself
        for (int d = 1; d <= LAT; d++) reset_during_write(d);

        // unmapped device address and RAM aliasing
        access(1'b0, 16'hFE10, 16'h0000, "t6 fe10");
        access(1'b1, 16'h0105, 16'h5A5A, "t6 wr alias");
        access(1'b0, 16'h0005, 16'h0000, "t6 rd alias");

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            op = int'($urandom_range(0, 9));
            if (op == 0) begin
                kbd_offer(8'($urandom));
            end else if (op == 1) begin
                disp_pulse();
            end else if (op <= 3) begin
                case ($urandom_range(0, 4))
                    0:       a = 16'hFE00;
                    1:       a = 16'hFE02;
                    2:       a = 16'hFE04;
                    3:       a = 16'hFE06;
                    default: a = 16'hFE00 + 16'($urandom_range(0, 511));
                endcase
                access(1'($urandom), a, 16'($urandom), "rnd io");
            end else begin
                a = 16'($urandom_range(0, 16'hFDFF));
                access(1'($urandom), a, 16'($urandom), "rnd ram");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
